vec_word_packer: RTL

//   Assembles narrow words from the PS/DMA stream into full VEC_WIDTH vectors.

---
 rtl/vec_word_packer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/vec_word_packer.sv
// vec_word_packer: assembles WORD_WIDTH words into VEC_WIDTH vectors and hands
// them downstream over a valid/ready handshake. One vector is held at the
// output while the next one is assembled in a separate register.
// Optional feature macro: VEC_PACK_LAST_FLUSH_EN. When it is defined, a word
// with in_last_i set completes the vector early and the upper words are zeroed.

`ifndef CFG_VEC_WIDTH
`define CFG_VEC_WIDTH 128
`endif

module vec_word_packer #(
  parameter int VEC_WIDTH  = `CFG_VEC_WIDTH,
  parameter int WORD_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  this_ready_o,
  input  logic [WORD_WIDTH-1:0] in_word_i,
  input  logic                  in_last_i,
  output logic                  out_valid_o,
  input  logic                  next_ready_i,
  output logic [VEC_WIDTH-1:0]  vec_o,
  output logic [CNT_WIDTH-1:0]  vec_count_o
);

  localparam int WORDS = VEC_WIDTH / WORD_WIDTH;
  localparam int WIDX  = $clog2(WORDS);
  localparam logic [WIDX-1:0] LAST_IDX = WIDX'(WORDS - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                state_q;
  logic [WIDX-1:0]       wcnt_q;
  logic [VEC_WIDTH-1:0]  asm_q;
  logic [VEC_WIDTH-1:0]  vec_q;
  logic                  out_valid_q;
  logic [CNT_WIDTH-1:0]  vec_count_q;

  logic [VEC_WIDTH-1:0]  merged_d;
  logic                  wordAccept;
  logic                  vecHandoff;
  logic                  lastHit;
  logic                  finalWord;

`ifdef VEC_PACK_LAST_FLUSH_EN
  assign lastHit = in_last_i;
`else
  logic unusedLast;
  assign unusedLast = in_last_i;
  assign lastHit    = 1'b0;
`endif

  // The packer only takes words while assembling; ready depends on state alone
  assign this_ready_o = (state_q == FILL);
  assign wordAccept   = in_valid_i && this_ready_o;
  assign vecHandoff   = out_valid_q && next_ready_i;
  assign finalWord    = wordAccept && ((wcnt_q == LAST_IDX) || lastHit);

  assign out_valid_o  = out_valid_q;
  assign vec_o        = vec_q;
  assign vec_count_o  = vec_count_q;

  // Assembly register with the incoming word inserted at its slot and every slot above cleared
  always_comb begin
    merged_d = asm_q;
    for (int k = 0; k < WORDS; k++) begin
      if (WIDX'(k) == wcnt_q) begin
        merged_d[k*WORD_WIDTH +: WORD_WIDTH] = in_word_i;
      end else if (WIDX'(k) > wcnt_q) begin
        merged_d[k*WORD_WIDTH +: WORD_WIDTH] = '0;
      end
    end
  end

  // FILL/HOLD state machine with registered output vector, valid and handoff counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FILL;
      wcnt_q      <= '0;
      asm_q       <= '0;
      vec_q       <= '0;
      out_valid_q <= 1'b0;
      vec_count_q <= '0;
    end else begin
      if (vecHandoff) begin
        vec_count_q <= vec_count_q + 1'b1;
      end
      case (state_q)
        FILL: begin
          if (finalWord) begin
            if (!out_valid_q || next_ready_i) begin
              vec_q       <= merged_d;
              out_valid_q <= 1'b1;
              wcnt_q      <= '0;
            end else begin
              asm_q   <= merged_d;
              state_q <= HOLD;
            end
          end else begin
            if (wordAccept) begin
              asm_q  <= merged_d;
              wcnt_q <= wcnt_q + 1'b1;
            end
            if (vecHandoff) begin
              out_valid_q <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (vecHandoff) begin
            vec_q   <= asm_q;
            wcnt_q  <= '0;
            state_q <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule
